instr_fetch_unit: RTL and testbench

Instruction fetch front end that produces the 32-bit instruction stream consumed by the core's instruction decoder. It keeps the 64-bit fetch PC, issues word requests to instruction memory over a valid/ready request channel, and accepts in-order responses. Fetched words are buffered with their PC in a small queue and presented to the decode stage over a valid/ready handshake. It also handles redirects, which flush and restart the stream, and fetch access faults.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode handshake and redirect.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, instr_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, instr_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited word requests, in-order responses buffered
// with their PC in a small queue toward decode, with redirect flush and fault halt.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW+1:0] DepthW = DEPTH[CW+1:0];

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e        state_q;
  logic [63:0]   fetch_pc_q, resp_pc_q;
  logic [CW-1:0] outstanding_q, drop_q, count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   word_q  [DEPTH];
  logic [63:0]   pc_q    [DEPTH];
  logic          fault_q [DEPTH];

  logic [CW+1:0] used;
  logic          credit, req_valid, req_fire, pop;
  logic          resp_drop, resp_halt, resp_keep;
  logic [63:0]   target;

  always_comb begin
    used      = {2'b00, outstanding_q} + {2'b00, drop_q} + {2'b00, count_q};
    credit    = used < DepthW;
    req_valid = !rst && (state_q == StRun) && credit && !bus.redirect_valid;
    req_fire  = req_valid && bus.imem_req_ready;
    pop       = (count_q != '0) && bus.instr_ready;
    // A response arriving with a redirect is charged to the pre-redirect counters.
    resp_drop = bus.imem_resp_valid && ((drop_q != '0) || bus.redirect_valid);
    resp_halt = bus.imem_resp_valid && !resp_drop && (state_q == StHalt);
    resp_keep = bus.imem_resp_valid && !resp_drop && (state_q == StRun);
    target    = bus.redirect_pc & ~64'h3;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = count_q != '0;
  assign bus.instruction    = word_q[rd_ptr_q];
  assign bus.instr_pc       = pc_q[rd_ptr_q];
  assign bus.instr_fault    = fault_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i]  <= '0;
        pc_q[i]    <= '0;
        fault_q[i] <= 1'b0;
      end
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 64'd4;
      end
      if (resp_keep) begin
        word_q[wr_ptr_q]  <= bus.imem_resp_data;
        pc_q[wr_ptr_q]    <= resp_pc_q;
        fault_q[wr_ptr_q] <= bus.imem_resp_err;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
        resp_pc_q         <= resp_pc_q + 64'd4;
        if (bus.imem_resp_err) begin
          state_q <= StHalt;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q       <= count_q + CW'(resp_keep) - CW'(pop);
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp_keep || resp_halt);
      drop_q        <= drop_q - CW'(resp_drop);

      // Redirect overrides all of the above: every kept request becomes a dropped one.
      if (bus.redirect_valid) begin
        state_q       <= StRun;
        fetch_pc_q    <= target;
        resp_pc_q     <= target;
        outstanding_q <= '0;
        drop_q        <= drop_q + outstanding_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
        count_q       <= '0;
        rd_ptr_q      <= wr_ptr_q;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with adjustable latency, request and
// delivery logs, and hand-computed expectations for each scenario.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus_if ();

  instr_fetch_unit #(
    .RESET_PC (64'h0),
    .DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
    logic        fault;
  } dent_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  int          checks    = 0;
  int          failures  = 0;
  int          lat       = 1;
  int          cyc       = 0;
  int          resp_seen = 0;
  logic [63:0] err_addr  = '1;
  logic        pend_fire = 1'b0;
  logic [63:0] pend_addr = '0;
  dent_t       dlog[$];
  logic [63:0] rlog[$];
  mreq_t       mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_dlog(input int n, input string tag);
    for (int i = 0; i < 40 && dlog.size() < n; i++) step();
    check(tag, 64'(dlog.size() >= n), 64'd1);
  endtask

  // Memory: responses in request order, data = addr[31:0], err when addr matches err_addr.
  initial begin
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    bus_if.imem_resp_err   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (pend_fire) mq.push_back('{addr: pend_addr, due: cyc + lat - 1});
      #1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = mq[0].addr[31:0];
        bus_if.imem_resp_err   = (mq[0].addr == err_addr);
        void'(mq.pop_front());
      end else begin
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
        bus_if.imem_resp_err   = 1'b0;
      end
      @(negedge clk);
      if (bus_if.imem_resp_valid) begin
        check("resp_has_req", 64'(rlog.size() > resp_seen), 64'd1);
        resp_seen++;
      end
      pend_fire = bus_if.imem_req_valid && bus_if.imem_req_ready;
      pend_addr = bus_if.imem_req_addr;
      if (pend_fire) rlog.push_back(pend_addr);
      if (bus_if.instr_valid && bus_if.instr_ready)
        dlog.push_back('{pc: bus_if.instr_pc, word: bus_if.instruction, fault: bus_if.instr_fault});
    end
  end

  initial begin
    int n;
    int nr;
    rst                   = 1'b1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;

    // Reset state
    step();
    check("rst_req_valid", bus_if.imem_req_valid, 0);
    check("rst_req_addr", bus_if.imem_req_addr, 64'h0);
    check("rst_instr_valid", bus_if.instr_valid, 0);
    check("rst_instruction", bus_if.instruction, 0);
    check("rst_instr_pc", bus_if.instr_pc, 0);
    check("rst_instr_fault", bus_if.instr_fault, 0);

    // Stream with 1-cycle memory
    rst = 1'b0;
    #1;
    check("first_req_valid", bus_if.imem_req_valid, 1);
    check("first_req_addr", bus_if.imem_req_addr, 64'h0);
    step();
    check("second_req_addr", bus_if.imem_req_addr, 64'h4);
    check("no_early_instr", bus_if.instr_valid, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", bus_if.instr_valid, 1);
      check("stream_pc", bus_if.instr_pc, 64'(4 * k));
      check("stream_word", bus_if.instruction, 64'(4 * k));
      step();
    end

    // Decode backpressure
    bus_if.instr_ready = 1'b0;
    repeat (10) step();
    check("bp_req_valid", bus_if.imem_req_valid, 0);
    check("bp_head_pc", bus_if.instr_pc, 64'h20);
    check("bp_inflight", 64'(rlog.size() - dlog.size()), 64'd4);
    n = dlog.size();
    bus_if.instr_ready = 1'b1;
    repeat (4) step();
    check("drain_count", 64'(dlog.size()), 64'(n + 4));
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", dlog[n+i].pc, 64'(32 + 4 * i));
      check("drain_word", dlog[n+i].word, 64'(32 + 4 * i));
    end

    // Redirect with 3 outstanding at latency 4
    bus_if.imem_req_ready = 1'b0;
    lat = 4;
    repeat (4) step();
    check("stall_drained", bus_if.instr_valid, 0);
    check("stall_req_valid", bus_if.imem_req_valid, 1);
    check("stall_req_addr", bus_if.imem_req_addr, 64'h3c);
    bus_if.imem_req_ready = 1'b1;
    repeat (3) step();
    n = dlog.size();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h1003;
    #1;
    check("redir_req_gated", bus_if.imem_req_valid, 0);
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    check("redir_next_valid", bus_if.imem_req_valid, 1);
    check("redir_next_addr", bus_if.imem_req_addr, 64'h1000);
    wait_dlog(n + 2, "redir_wait");
    check("redir_first_pc", dlog[n].pc, 64'h1000);
    check("redir_first_word", dlog[n].word, 64'h1000);
    check("redir_second_pc", dlog[n+1].pc, 64'h1004);

    // Fault on the response for 0x8
    err_addr = 64'h8;
    lat      = 1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h0;
    step();
    bus_if.redirect_valid = 1'b0;
    n = dlog.size();
    wait_dlog(n + 3, "fault_wait");
    check("fault_pc0", dlog[n].pc, 64'h0);
    check("fault_flag0", dlog[n].fault, 0);
    check("fault_pc4", dlog[n+1].pc, 64'h4);
    check("fault_pc8", dlog[n+2].pc, 64'h8);
    check("fault_flag8", dlog[n+2].fault, 1);
    nr = rlog.size();
    n  = dlog.size();
    repeat (8) step();
    check("halt_no_req", 64'(rlog.size()), 64'(nr));
    check("halt_no_deliver", 64'(dlog.size()), 64'(n));
    check("halt_req_valid", bus_if.imem_req_valid, 0);
    check("halt_instr_valid", bus_if.instr_valid, 0);
    err_addr = '1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h40;
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    check("resume_valid", bus_if.imem_req_valid, 1);
    check("resume_addr", bus_if.imem_req_addr, 64'h40);
    n = dlog.size();
    wait_dlog(n + 1, "resume_wait");
    check("resume_pc", dlog[n].pc, 64'h40);
    check("resume_fault", dlog[n].fault, 0);

    // Request channel stall with a redirect in the middle
    bus_if.imem_req_ready = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h100;
    #1;
    check("rs_redir_gated", bus_if.imem_req_valid, 0);
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    check("rs_valid", bus_if.imem_req_valid, 1);
    check("rs_addr_a", bus_if.imem_req_addr, 64'h100);
    step();
    check("rs_addr_b", bus_if.imem_req_addr, 64'h100);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h200;
    #1;
    check("rs_mid_gated", bus_if.imem_req_valid, 0);
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    check("rs_new_valid", bus_if.imem_req_valid, 1);
    check("rs_new_addr", bus_if.imem_req_addr, 64'h200);
    step();
    check("rs_new_held", bus_if.imem_req_addr, 64'h200);
    nr = rlog.size();
    n  = dlog.size();
    bus_if.imem_req_ready = 1'b1;
    wait_dlog(n + 1, "rs_wait");
    check("rs_first_req", rlog[nr], 64'h200);
    check("rs_first_pc", dlog[n].pc, 64'h200);

    // Pop + response arrival + outstanding request + redirect in one cycle
    lat = 2;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h300;
    step();
    bus_if.redirect_valid = 1'b0;
    repeat (7) step();
    check("sim_head_valid", bus_if.instr_valid, 1);
    check("sim_head_pc", bus_if.instr_pc, 64'h310);
    n = dlog.size();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h500;
    #1;
    check("sim_req_gated", bus_if.imem_req_valid, 0);
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    check("sim_flushed", bus_if.instr_valid, 0);
    check("sim_next_addr", bus_if.imem_req_addr, 64'h500);
    check("sim_pop_count", 64'(dlog.size()), 64'(n + 1));
    check("sim_pop_pc", dlog[n].pc, 64'h310);
    wait_dlog(n + 2, "sim_wait");
    check("sim_after_pc", dlog[n+1].pc, 64'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
